mac512_stream_sequencer: RTL
============================

Name: mac512_stream_sequencer

Overview:
- Front-end and back-end sequencer for the 256x256 shift-add CLA multiply-accumulate core.
- Accepts operands as a stream of narrow words, assembles 256-bit A and B, and clears the core. It then enables the core for its fixed iteration count, captures the 512-bit product and streams it back out as narrow words.
- Sits directly between the system word bus and the multiplier's A/B/en/rst_n/out pins.

Parameters:
- WORD_W, 32, width of input/output stream words.
- OP_W, 256, operand width; OP_W/WORD_W must be an integer (8 at defaults).
- MUL_CYCLES, 256, number of clk cycles mul_en is held high per multiply (core iteration count).

Ports:
- clk  input  1  rising-edge clock, shared with the multiplier core.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WORD_W  operand word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sequencer can accept a word.
- out_data  output  WORD_W  product word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts a word.
- out_last  output  1  marks final product word.
- busy  output  1  high in CLEAR, RUN, CAPTURE.
- mul_a  output  OP_W  operand A to core.
- mul_b  output  OP_W  operand B to core.
- mul_en  output  1  core enable.
- mul_rst_n  output  1  core reset, active-low.
- mul_out  input  2*OP_W  core product.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Transfers: a transfer occurs on a rising edge with valid&ready high.
- Reset values:
  - state=LOAD_A; word counter=0; cycle counter=0.
  - mul_a=0, mul_b=0, result register=0.
  - mul_en=0, mul_rst_n=0 (held low while rst is high).
  - in_ready=0 while rst is high; out_valid=0, out_last=0, busy=0.
- All outputs are decoded from registered state/counters; there are no combinational in->out paths.
- LOAD_A:
  - in_ready=1.
  - Each accepted word k (k=0..7) is written to mul_a[k*WORD_W +: WORD_W], least-significant word first.
  - After word 7 is accepted -> LOAD_B, counter=0.
- LOAD_B: same as LOAD_A, writing into mul_b. After word 7 is accepted -> CLEAR.
- CLEAR (1 cycle): mul_rst_n=0, mul_en=0, in_ready=0. -> RUN.
- RUN:
  - mul_rst_n=1, mul_en=1 for exactly MUL_CYCLES consecutive cycles.
  - The cycle counter counts 0..MUL_CYCLES-1; at the terminal count -> CAPTURE.
  - mul_a/mul_b are held stable throughout.
- CAPTURE (1 cycle): mul_en=0; the result register loads mul_out. -> UNLOAD, counter=0.
- UNLOAD:
  - out_valid=1; out_data = result[k*WORD_W +: WORD_W] for k=0..15, LS word first.
  - out_last=1 only while k=15.
  - k advances only on out_valid&out_ready.
  - out_data is held stable while out_ready=0 (backpressure of any length).
  - After word 15 is accepted -> LOAD_A.
- mul_a/mul_b retain their last values until overwritten by the next load.
- in_ready=0 in every state except LOAD_A/LOAD_B; in_valid is ignored there.
- Latency, from the acceptance edge of the last B word:
  - CLEAR is the next cycle.
  - mul_en rises the cycle after CLEAR.
  - out_valid rises MUL_CYCLES+2 cycles after CLEAR.
- Back-to-back operation: the first word of the next A is accepted no earlier than the cycle after out_last is accepted.
- rst asserted in any state:
  - Aborts the operation immediately.
  - Discards partial operands and product.
  - Returns to the reset values; no output word is emitted afterward for the aborted operation.
- in_valid=0 mid-load pauses the word counter; there is no timeout.

Test Plan:
- Small operands: load A=32, B=32, out_ready=1 -> mul_en high exactly 256 cycles; words: word0=0x00000400, words1..15=0, out_last on word15.
- Second operation, back-to-back: load A=5, B=10 -> word0=0x00000032, rest 0. Then A=100, B=100 -> word0=0x00002710, rest 0.
- Maximum operands: A=B=2^256-1 -> word0=1, words1..7=0, word8=0xFFFFFFFE, words9..15=0xFFFFFFFF.
- Backpressure:
  - Output side: toggle out_ready randomly during UNLOAD -> all 16 words appear in order, each stable until accepted, none duplicated or dropped.
  - Input side: gaps in in_valid during LOAD -> same product as the no-gap case.
- Reset mid-RUN: assert rst at cycle 100 of RUN -> mul_en=0 and mul_rst_n=0 immediately; state LOAD_A after release; no output words; the next full operation (A=3, B=7) -> word0=0x15.
- Cycle-exact latency: check CLEAR occurs 1 cycle after the last B word, mul_rst_n low exactly 1 cycle, and first out_valid exactly MUL_CYCLES+2 cycles after CLEAR.

Source files
------------

// File: rtl/mac512_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac512_stream_sequencer
// Purpose  : Word-stream front/back end for the 256x256 shift-add multiply-
//            accumulate core. Assembles operands A and B from WORD_W-bit input
//            words, clears the core for one cycle, enables it for MUL_CYCLES
//            cycles, captures the 2*OP_W product and streams it back out as
//            WORD_W-bit words, least-significant word first.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            in_data/in_valid/in_ready            - operand word stream
//            out_data/out_valid/out_ready/out_last - product word stream
//            busy             - high in CLEAR, RUN and CAPTURE
//            mul_a/mul_b/mul_en/mul_rst_n/mul_out - multiplier core pins
// Notes    : OP_W must be an integer multiple of WORD_W.
// Revision : 1.0 - initial release
// ============================================================================
module mac512_stream_sequencer #(
    parameter int WORD_W     = 32,
    parameter int OP_W       = 256,
    parameter int MUL_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic [OP_W-1:0]     mul_a,
    output logic [OP_W-1:0]     mul_b,
    output logic                mul_en,
    output logic                mul_rst_n,
    input  logic [2*OP_W-1:0]   mul_out
);

    localparam int N_IN  = OP_W / WORD_W;
    localparam int N_OUT = 2 * N_IN;
    localparam int CNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CYC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [2:0] S_LOAD_A  = 3'd0;
    localparam logic [2:0] S_LOAD_B  = 3'd1;
    localparam logic [2:0] S_CLEAR   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_UNLOAD  = 3'd5;

    logic [2:0]        state_q,     state_d;
    logic [CNT_W-1:0]  word_cnt_q,  word_cnt_d;
    logic [CYC_W-1:0]  cyc_cnt_q,   cyc_cnt_d;
    logic [OP_W-1:0]   mul_a_q,     mul_a_d;
    logic [OP_W-1:0]   mul_b_q,     mul_b_d;
    logic [2*OP_W-1:0] result_q,    result_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic              busy_q,      busy_d;
    logic              mul_en_q,    mul_en_d;
    logic              mul_rst_n_q, mul_rst_n_d;

    // Handshakes use only the registered ready/valid, so no input reaches an
    // output combinationally.
    logic in_fire;
    logic out_fire;
    assign in_fire  = in_valid  & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // ------------------------------------------------------------------
    // State register (plus counters and datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD_A;
            word_cnt_q  <= '0;
            cyc_cnt_q   <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            mul_en_q    <= 1'b0;
            mul_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            mul_en_q    <= mul_en_d;
            mul_rst_n_q <= mul_rst_n_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        case (state_q)
            S_LOAD_A: begin
                if (in_fire) begin
                    if (word_cnt_q == CNT_W'(N_IN - 1)) begin
                        state_d    = S_LOAD_B;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_B: begin
                if (in_fire) begin
                    if (word_cnt_q == CNT_W'(N_IN - 1)) begin
                        state_d    = S_CLEAR;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_d   = S_RUN;
                cyc_cnt_d = '0;
            end
            S_RUN: begin
                if (cyc_cnt_q == CYC_W'(MUL_CYCLES - 1)) begin
                    state_d   = S_CAPTURE;
                    cyc_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d    = S_UNLOAD;
                word_cnt_d = '0;
            end
            S_UNLOAD: begin
                if (out_fire) begin
                    if (word_cnt_q == CNT_W'(N_OUT - 1)) begin
                        state_d    = S_LOAD_A;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = S_LOAD_A;
                word_cnt_d = '0;
                cyc_cnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand assembly and product capture
    // ------------------------------------------------------------------
    always_comb begin
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        result_d = result_q;
        for (int k = 0; k < N_IN; k++) begin
            if (word_cnt_q == CNT_W'(k)) begin
                if (state_q == S_LOAD_A && in_fire) mul_a_d[k*WORD_W +: WORD_W] = in_data;
                if (state_q == S_LOAD_B && in_fire) mul_b_d[k*WORD_W +: WORD_W] = in_data;
            end
        end
        // The core has been idle (mul_en low) for this cycle, so mul_out is settled.
        if (state_q == S_CAPTURE) result_d = mul_out;
    end

    // ------------------------------------------------------------------
    // Output decode. Decoded from the next state and registered, so every
    // output comes straight from a flop and sits at its reset value while
    // rst is held (in particular in_ready and mul_rst_n stay low).
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        out_valid_d = (state_d == S_UNLOAD);
        out_last_d  = (state_d == S_UNLOAD) && (word_cnt_d == CNT_W'(N_OUT - 1));
        busy_d      = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_CAPTURE);
        mul_en_d    = (state_d == S_RUN);
        mul_rst_n_d = (state_d != S_CLEAR);
    end

    // Output word mux over the captured product.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (word_cnt_q == CNT_W'(k)) out_data = result_q[k*WORD_W +: WORD_W];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_en    = mul_en_q;
    assign mul_rst_n = mul_rst_n_q;

endmodule
`default_nettype wire
